// File: rtl/axi_stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_stream_rr_arbiter
//
// Purpose:
//   Shares one AXI4-Stream master port between num_inputs stream sources.
//   Arbitration is round-robin at packet granularity. Once an input is
//   granted, the grant is held until that input's tlast beat completes its
//   handshake. Nothing is buffered: the data beats pass combinationally
//   from the granted input to the output.
//
// Ports:
//   clk       - clock; all state updates on the rising edge
//   resetn    - asynchronous active-low reset
//   s_tvalid  - per-input tvalid                    [num_inputs]
//   s_tready  - per-input tready                    [num_inputs]
//   s_tdata   - packed tdata, input i in slice i    [num_inputs*8*byte_width]
//   s_tkeep   - packed tkeep, input i in slice i    [num_inputs*byte_width]
//   s_tlast   - per-input tlast                     [num_inputs]
//   m_tvalid  - output tvalid
//   m_tready  - output tready
//   m_tdata   - tdata of the granted input          [8*byte_width]
//   m_tkeep   - tkeep of the granted input          [byte_width]
//   m_tlast   - tlast of the granted input
//   m_tid     - index of the granted input          [idx_width]
//   busy      - high while a grant is held
// ---------------------------------------------------------------------------
module axi_stream_rr_arbiter #(
    parameter int num_inputs = 4,
    parameter int byte_width = 4,
    parameter int idx_width  = $clog2(num_inputs)
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [num_inputs-1:0]              s_tvalid,
    output logic [num_inputs-1:0]              s_tready,
    input  logic [num_inputs*8*byte_width-1:0] s_tdata,
    input  logic [num_inputs*byte_width-1:0]   s_tkeep,
    input  logic [num_inputs-1:0]              s_tlast,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic [8*byte_width-1:0]            m_tdata,
    output logic [byte_width-1:0]              m_tkeep,
    output logic                               m_tlast,
    output logic [idx_width-1:0]               m_tid,
    output logic                               busy
);

    localparam int DATA_W = 8 * byte_width;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [idx_width-1:0] grant_q, grant_d;
    logic [idx_width-1:0] ptr_q,   ptr_d;

    // Unpacked views of the packed input buses so the mux is a plain index.
    logic [DATA_W-1:0]     tdata_arr [num_inputs];
    logic [byte_width-1:0] tkeep_arr [num_inputs];

    generate
        for (genvar gi = 0; gi < num_inputs; gi++) begin : g_unpack
            assign tdata_arr[gi] = s_tdata[gi*DATA_W +: DATA_W];
            assign tkeep_arr[gi] = s_tkeep[gi*byte_width +: byte_width];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin pick: first requesting input scanning ptr+1, ptr+2, ...
    // modulo num_inputs. The candidate index carries one extra bit so that
    // ptr + k never overflows before the wrap is applied.
    // -----------------------------------------------------------------------
    logic                 pick_valid;
    logic [idx_width-1:0] pick_idx;
    logic [idx_width:0]   cand;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= num_inputs; k++) begin
            cand = {1'b0, ptr_q} + (idx_width+1)'(k);
            if (cand >= (idx_width+1)'(num_inputs)) begin
                cand = cand - (idx_width+1)'(num_inputs);
            end
            if (!pick_valid && s_tvalid[cand[idx_width-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[idx_width-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            // Last-served pointer starts at the top so input 0 wins first.
            ptr_q   <= idx_width'(num_inputs - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    logic last_beat_done;
    assign last_beat_done = m_tvalid && m_tready && m_tlast;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // The finishing input becomes lowest priority; requests that
                // arrive now are only looked at in the following IDLE cycle.
                if (last_beat_done) begin
                    ptr_d   = grant_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: combinational from registered state/grant plus live
    // inputs, so reset assertion drops m_tvalid/s_tready immediately.
    // -----------------------------------------------------------------------
    always_comb begin
        s_tready = '0;
        m_tvalid = 1'b0;
        busy     = 1'b0;
        m_tdata  = tdata_arr[grant_q];
        m_tkeep  = tkeep_arr[grant_q];
        m_tlast  = s_tlast[grant_q];
        m_tid    = grant_q;
        if (state_q == BUSY) begin
            busy              = 1'b1;
            m_tvalid          = s_tvalid[grant_q];
            s_tready[grant_q] = m_tready;
        end
    end

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_rr_arbiter
//
// Purpose:
//   Directed, self-checking bench for axi_stream_rr_arbiter with four 32-bit
//   inputs. Inputs are driven 1 time unit after the rising edge; outputs are
//   sampled 3 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_axi_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int BW = 4;
    localparam int DW = 8 * BW;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [N*DW-1:0]   s_tdata;
    logic [N*BW-1:0]   s_tkeep;
    logic [N-1:0]      s_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic [BW-1:0]     m_tkeep;
    logic              m_tlast;
    logic [IW-1:0]     m_tid;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axi_stream_rr_arbiter #(
        .num_inputs (N),
        .byte_width (BW),
        .idx_width  (IW)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [DW-1:0] d,
                         input logic [BW-1:0] k, input logic l);
        s_tvalid[i]          = v;
        s_tdata[i*DW +: DW]  = d;
        s_tkeep[i*BW +: BW]  = k;
        s_tlast[i]           = l;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        resetn   = 1'b0;

        // ---------------- reset state ----------------
        #2;
        chk("rst m_tvalid", m_tvalid, 0);
        chk("rst s_tready", s_tready, 0);
        chk("rst busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // ---------------- idle 10 cycles ----------------
        for (int c = 0; c < 10; c++) begin
            step();
            #2;
            chk("idle {m_tvalid,s_tready,busy}", {m_tvalid, s_tready, busy}, 0);
        end

        // ---------------- all inputs request, 1-beat packets ----------------
        // Pointer still at its reset value, so order is 0,1,2,3,0,1.
        step();
        m_tready = 1'b1;
        for (int i = 0; i < N; i++) drive(i, 1'b1, DW'(32'h10 + i), BW'(1 << i), 1'b1);
        for (int p = 0; p < 6; p++) begin
            #2;
            chk("rr idle gap m_tvalid", m_tvalid, 0);
            step();
            #2;
            chk("rr m_tvalid", m_tvalid, 1);
            chk("rr m_tid", m_tid, p % 4);
            chk("rr m_tdata", m_tdata, 32'h10 + (p % 4));
            chk("rr m_tkeep", m_tkeep, 1 << (p % 4));
            chk("rr s_tready", s_tready, 1 << (p % 4));
            step();
        end
        for (int i = 0; i < N; i++) drive(i, 1'b0, '0, '0, 1'b0);

        // ---------------- single requester, input 2, 3 beats ----------------
        drive(2, 1'b1, 32'hA1, 4'hF, 1'b0);
        #2;
        chk("single first cycle m_tvalid", m_tvalid, 0);
        chk("single first cycle busy", busy, 0);
        step();
        #2;
        chk("single beat1 m_tid", m_tid, 2);
        chk("single beat1 m_tdata", m_tdata, 32'hA1);
        chk("single beat1 m_tlast", m_tlast, 0);
        chk("single beat1 busy", busy, 1);
        step();
        drive(2, 1'b1, 32'hA2, 4'hF, 1'b0);
        #2;
        chk("single beat2 m_tdata", m_tdata, 32'hA2);
        step();
        drive(2, 1'b1, 32'hA3, 4'hF, 1'b1);
        #2;
        chk("single beat3 m_tdata", m_tdata, 32'hA3);
        chk("single beat3 m_tlast", m_tlast, 1);
        chk("single beat3 s_tready", s_tready, 4'b0100);
        step();
        drive(2, 1'b0, '0, '0, 1'b0);
        #2;
        chk("single after busy", busy, 0);
        chk("single after m_tvalid", m_tvalid, 0);

        // ---------------- backpressure on input 1 ----------------
        m_tready = 1'b0;
        drive(1, 1'b1, 32'h55, 4'hF, 1'b1);
        #2;
        chk("bp idle m_tvalid", m_tvalid, 0);
        step();
        for (int c = 0; c < 5; c++) begin
            #2;
            chk("bp held m_tvalid", m_tvalid, 1);
            chk("bp held m_tdata", m_tdata, 32'h55);
            chk("bp held s_tready", s_tready, 0);
            chk("bp held m_tid", m_tid, 1);
            step();
        end
        m_tready = 1'b1;
        #2;
        chk("bp release s_tready", s_tready, 4'b0010);
        chk("bp release m_tvalid", m_tvalid, 1);
        step();
        drive(1, 1'b0, '0, '0, 1'b0);
        #2;
        chk("bp done busy", busy, 0);

        // ---------------- mid-packet gap on input 3 ----------------
        drive(3, 1'b1, 32'hB1, 4'hF, 1'b0);
        #2;
        chk("gap idle m_tvalid", m_tvalid, 0);
        step();
        #2;
        chk("gap beat1 m_tid", m_tid, 3);
        chk("gap beat1 m_tdata", m_tdata, 32'hB1);
        step();
        drive(3, 1'b0, 32'hB1, 4'hF, 1'b0);
        drive(0, 1'b1, 32'hC0, 4'hF, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("gap hole m_tvalid", m_tvalid, 0);
            chk("gap hole busy", busy, 1);
            chk("gap hole m_tid", m_tid, 3);
            chk("gap hole s_tready", s_tready, 4'b1000);
            step();
        end
        drive(3, 1'b1, 32'hB2, 4'hF, 1'b1);
        #2;
        chk("gap last m_tvalid", m_tvalid, 1);
        chk("gap last m_tdata", m_tdata, 32'hB2);
        chk("gap last m_tlast", m_tlast, 1);
        step();
        drive(3, 1'b0, '0, '0, 1'b0);
        #2;
        chk("gap after m_tvalid", m_tvalid, 0);
        chk("gap after busy", busy, 0);
        step();
        #2;
        chk("gap next m_tid", m_tid, 0);
        chk("gap next m_tdata", m_tdata, 32'hC0);
        step();
        drive(0, 1'b0, '0, '0, 1'b0);
        #2;
        chk("gap next done busy", busy, 0);

        // ---------------- asynchronous reset mid-packet ----------------
        drive(2, 1'b1, 32'hD1, 4'hF, 1'b0);
        #2;
        chk("arst idle m_tvalid", m_tvalid, 0);
        step();
        #2;
        chk("arst beat1 m_tid", m_tid, 2);
        chk("arst beat1 m_tdata", m_tdata, 32'hD1);
        step();
        drive(2, 1'b1, 32'hD2, 4'hF, 1'b0);
        drive(0, 1'b1, 32'hE0, 4'hF, 1'b1);
        drive(1, 1'b1, 32'hE1, 4'hF, 1'b1);
        #2;
        chk("arst beat2 m_tdata", m_tdata, 32'hD2);
        resetn = 1'b0;
        #1;
        chk("arst during m_tvalid", m_tvalid, 0);
        chk("arst during s_tready", s_tready, 0);
        chk("arst during busy", busy, 0);
        repeat (2) step();
        resetn = 1'b1;
        #2;
        chk("arst release m_tvalid", m_tvalid, 0);
        step();
        #2;
        chk("arst regrant m_tid", m_tid, 0);
        chk("arst regrant m_tdata", m_tdata, 32'hE0);
        step();
        for (int i = 0; i < N; i++) drive(i, 1'b0, '0, '0, 1'b0);
        #2;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_stream_rr_arbiter.md
Name: axi_stream_rr_arbiter

Overview:
- N-input to 1-output AXI4-Stream packet arbiter. Several stream masters share one downstream slave port.
- Arbitration is round-robin at packet granularity: a grant is held from the first beat until the beat with tlast completes its handshake.
- The output port is legal AXI4-Stream and must pass axi_stream_slave_monitor when that monitor is attached to the output.

Parameters:
num_inputs, 4, number of slave (input) stream ports; must be >= 2
byte_width, 4, tdata width in bytes; tkeep width = byte_width
idx_width, $clog2(num_inputs), width of the grant index and of m_tid

Ports:
clk  input  1  clock; all state updates on rising edge
resetn  input  1  reset, asynchronous, active-low
s_tvalid  input  num_inputs  per-input tvalid
s_tready  output  num_inputs  per-input tready
s_tdata  input  num_inputs*8*byte_width  packed tdata; input i occupies slice i
s_tkeep  input  num_inputs*byte_width  packed tkeep
s_tlast  input  num_inputs  per-input tlast
m_tvalid  output  1  output tvalid
m_tready  input  1  output tready
m_tdata  output  8*byte_width  muxed tdata
m_tkeep  output  byte_width  muxed tkeep
m_tlast  output  1  muxed tlast
m_tid  output  idx_width  index of the granted input
busy  output  1  high while a grant is held (state BUSY)

Behaviour:
- Reset (resetn low, takes effect asynchronously):
  - state=IDLE, grant=0, ptr=num_inputs-1 (so input 0 has first priority).
  - m_tvalid=0, s_tready=all 0, busy=0.
- Outputs are combinational from registered state/grant plus live inputs. m_tvalid therefore drops in the same cycle resetn falls.
- IDLE:
  - m_tvalid=0, s_tready=0, m_tdata/m_tkeep/m_tlast/m_tid are don't-care (drive input `grant` slice).
  - If any s_tvalid is set, pick the first set bit scanning (ptr+1), (ptr+2), ... modulo num_inputs.
  - Register that index into grant; next state BUSY. If no s_tvalid is set, stay in IDLE.
- BUSY:
  - m_tvalid=s_tvalid[grant]; s_tready[grant]=m_tready; all other s_tready=0.
  - m_tdata/m_tkeep/m_tlast come from slice `grant`; m_tid=grant; busy=1.
- BUSY exit: on the cycle where m_tvalid && m_tready && m_tlast, set ptr<=grant and state<=IDLE.
- Latency:
  - One dead cycle in IDLE per packet.
  - A 1-beat packet takes at least 2 cycles; a k-beat packet takes at least k+1 cycles.
  - Data beats pass combinationally, with 0 cycles of latency.
- Lock: a granted input may drop tvalid between beats (legal). The arbiter stays in BUSY with m_tvalid=0 until tlast handshakes; there is no timeout.
- Non-granted inputs see tready=0, so their held tvalid and data are unaffected (they stay legal).
- Output stability: while m_tvalid && !m_tready, the grant cannot change, so m_tdata/m_tkeep/m_tlast/m_tid are stable because the granted source is stable.
- Fairness: after input i's packet ends, i has the lowest priority. Any continuously requesting input is granted within num_inputs-1 packets.
- Simultaneous events:
  - A new request arriving in the same cycle as the tlast handshake is only considered in the following IDLE cycle.
  - In IDLE, all requests are arbitrated together.
- Reset mid-packet: the packet is truncated (no tlast is emitted). After reset, arbitration restarts from input 0.
- No data is stored; there is no buffering and no overflow condition.

Test Plan:
- Reset then idle: no s_tvalid for 10 cycles -> m_tvalid=0, s_tready=0, busy=0, ptr unchanged.
- Single requester, input 2, 3-beat packet, tdata 0xA1/0xA2/0xA3, tlast on the 3rd beat, m_tready=1 -> output beats appear on cycles 2-4 after the request with m_tid=2; busy falls after the 3rd beat; total 4 cycles.
- All 4 inputs request continuously, 1-beat packets -> grant order 0,1,2,3,0,1...; each output beat is separated by one IDLE cycle.
- Backpressure: input 1 granted, m_tready=0 for 5 cycles while tdata=0x55 -> m_tvalid held at 1, m_tdata stable at 0x55, s_tready[1]=0 throughout; the beat transfers on the first cycle m_tready=1.
- Mid-packet gap: input 3 sends beat 1, drops tvalid for 3 cycles while input 0 requests, then sends the tlast beat -> grant stays 3, s_tready[0]=0; input 0 is granted only after the tlast handshake.
- Async reset mid-packet: resetn pulled low between clock edges during beat 2 of 4 -> m_tvalid and s_tready go to 0 immediately; after release, input 0 (if requesting) is granted first.
